// File: rtl/jk_pkg.sv
// Shared mode encoding for the JK register/counter bank.
package jk_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_JK   = 2'b01;
  localparam logic [1:0] MODE_UP   = 2'b10;
  localparam logic [1:0] MODE_DN   = 2'b11;

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop with synchronous active-low reset to a per-cell value.
module jk_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic rst_val,
  input  logic j,
  input  logic k,
  output logic q,
  output logic q_n
);

  logic q_reg;
  logic q_next;

  always_comb begin
    q_next = q_reg;
    case ({j, k})
      2'b00: q_next = q_reg;
      2'b10: q_next = 1'b1;
      2'b01: q_next = 1'b0;
      2'b11: q_next = ~q_reg;
      default: q_next = q_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_reg <= rst_val;
    end else begin
      q_reg <= q_next;
    end
  end

  // Complement is derived, never stored, so it cannot drift from q.
  assign q   = q_reg;
  assign q_n = ~q_reg;

endmodule

// File: rtl/jk_reg_counter.sv
// WIDTH-bit bank of JK cells acting as a JK register or an up/down counter
// whose counting comes from toggle chains driving the cells' J/K inputs.
module jk_reg_counter
  import jk_pkg::*;
#(
  parameter int          WIDTH     = 4,
  parameter logic [31:0] RESET_VAL = 32'h0,
  parameter bit          SATURATE  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_n,
  output logic             tc
);

  logic [WIDTH-1:0] t_up;
  logic [WIDTH-1:0] t_dn;
  logic [WIDTH-1:0] j_cell;
  logic [WIDTH-1:0] k_cell;
  logic             at_max;
  logic             at_min;

  assign at_max = &q;
  assign at_min = ~|q;
  assign tc     = en & (((mode == MODE_UP) & at_max) | ((mode == MODE_DN) & at_min));

  // Bit i toggles once every lower bit is 1 (up) or every lower bit is 0 (down).
  assign t_up[0] = 1'b1;
  assign t_dn[0] = 1'b1;

  genvar gi;
  generate
    for (gi = 1; gi < WIDTH; gi++) begin : g_chain
      assign t_up[gi] = t_up[gi-1] & q[gi-1];
      assign t_dn[gi] = t_dn[gi-1] & q_n[gi-1];
    end
  endgenerate

  always_comb begin
    j_cell = '0;
    k_cell = '0;
    // Saturation parks the counter at its limit by starving every cell of J/K.
    if (en && !(SATURATE && tc)) begin
      case (mode)
        MODE_JK: begin
          j_cell = j;
          k_cell = k;
        end
        MODE_UP: begin
          j_cell = t_up;
          k_cell = t_up;
        end
        MODE_DN: begin
          j_cell = t_dn;
          k_cell = t_dn;
        end
        default: begin
          j_cell = '0;
          k_cell = '0;
        end
      endcase
    end
  end

  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_cell
      jk_cell u_cell (
        .clk     (clk),
        .rst_n   (rst_n),
        .rst_val (RESET_VAL[gi]),
        .j       (j_cell[gi]),
        .k       (k_cell[gi]),
        .q       (q[gi]),
        .q_n     (q_n[gi])
      );
    end
  endgenerate

endmodule
